// File: rtl/openframe_gpio_wb_if.sv
// Wishbone classic bus bundle between the openframe wrapper (master) and the GPIO block (slave).
interface openframe_gpio_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/openframe_gpio_wb.sv
// Wishbone-slave GPIO controller: pad output/enable registers, synchronized inputs and
// rising-edge interrupt status with per-bit enables. Pads [NUM_IO-1:32] live in the *_HI words.
module openframe_gpio_wb #(
  parameter int NUM_IO      = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic               core_clk,
  input  logic               core_rstn,
  openframe_gpio_wb_if.slave wb,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  output logic               irq
);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e            state_q, state_d;
  logic [NUM_IO-1:0] out_q, out_d, oeb_q, oeb_d, ien_q, ien_d, ist_q, ist_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] prev_q, sync_last, rise, w1c, rd_src;
  logic [31:0]       dat_q, dat_d, rd_word;
  logic              irq_q, access, half;
  logic [3:0]        word;
  logic              unused_adr;

  assign word       = wb.wb_adr_i[5:2];
  assign half       = word[0];
  assign unused_adr = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0]};
  // A strobe still high while in S_ACK belongs to the transfer already executed.
  assign access     = (state_q == S_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign sync_last  = sync_q[SYNC_STAGES-1];
  assign rise       = sync_last & ~prev_q;

  always_comb begin : read_mux
    unique case (word[3:1])
      3'd0:    rd_src = out_q;
      3'd1:    rd_src = oeb_q;
      3'd2:    rd_src = sync_last;
      3'd3:    rd_src = ien_q;
      3'd4:    rd_src = ist_q;
      default: rd_src = '0;
    endcase
    rd_word = '0;
    for (int i = 0; i < NUM_IO; i++)
      if ((i >= 32) == half) rd_word[i % 32] = rd_src[i];
  end

  always_comb begin : next_state
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    dat_d   = '0;
    out_d   = out_q;
    oeb_d   = oeb_q;
    ien_d   = ien_q;
    w1c     = '0;
    unique case (state_q)
      S_IDLE: if (access) begin
        state_d = S_ACK;
        dat_d   = rd_word;
      end
      S_ACK:  state_d = S_IDLE;
    endcase
    if (access && wb.wb_we_i) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (((i >= 32) == half) && wb.wb_sel_i[(i % 32) / 8]) begin
          unique case (word[3:1])
            3'd0:    out_d[i] = wb.wb_dat_i[i % 32];
            3'd1:    oeb_d[i] = wb.wb_dat_i[i % 32];
            3'd3:    ien_d[i] = wb.wb_dat_i[i % 32];
            3'd4:    w1c[i]   = wb.wb_dat_i[i % 32];
            default: ;
          endcase
        end
      end
    end
    // A rising edge in the same cycle as its W1C keeps the status bit set.
    ist_d = (ist_q & ~w1c) | rise;
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= S_IDLE;
      dat_q   <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      ien_q   <= '0;
      ist_q   <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      // NOTE: non-blocking so every flop, including each sync stage, samples pre-edge values.
      state_q   <= state_d;
      dat_q     <= dat_d;
      out_q     <= out_d;
      oeb_q     <= oeb_d;
      ien_q     <= ien_d;
      ist_q     <= ist_d;
      prev_q    <= sync_last;
      irq_q     <= |(ist_q & ien_q);
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign wb.wb_ack_o = (state_q == S_ACK);
  assign wb.wb_dat_o = dat_q;
  assign io_out      = out_q;
  assign io_oeb      = oeb_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_openframe_gpio_wb.sv
// Self-checking bench for openframe_gpio_wb: directed register-map scenarios plus random
// bus traffic and pad activity, compared against a transaction-level register model.
module tb_openframe_gpio_wb;
  localparam int          NUM_IO      = 38;
  localparam int          SYNC_STAGES = 2;
  localparam logic [63:0] VALID       = (64'h1 << NUM_IO) - 64'h1;

  logic              core_clk;
  logic              core_rstn;
  logic [NUM_IO-1:0] io_in;
  logic [NUM_IO-1:0] io_out;
  logic [NUM_IO-1:0] io_oeb;
  logic              irq;

  openframe_gpio_wb_if wb_if ();

  openframe_gpio_wb #(.NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES)) dut (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .wb       (wb_if.slave),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen = 0;

  // Register model: one 64-bit image per register, bits above NUM_IO always 0.
  logic [63:0] m_out, m_oeb, m_ien, m_ist;
  logic        m_irq;
  logic [63:0] hist[$];  // io_in seen at past edges, newest first
  bit          acc_pend, acc_we, exp_ack, adr_noise;
  logic [3:0]  acc_word, acc_sel;
  logic [31:0] acc_dat, exp_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [63:0] hget(input int k);
    return (k < hist.size()) ? hist[k] : 64'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] w, input logic [63:0] in_seen);
    case (w)
      4'd0:    return m_out[31:0];
      4'd1:    return m_out[63:32];
      4'd2:    return m_oeb[31:0];
      4'd3:    return m_oeb[63:32];
      4'd4:    return in_seen[31:0];
      4'd5:    return in_seen[63:32];
      4'd6:    return m_ien[31:0];
      4'd7:    return m_ien[63:32];
      4'd8:    return m_ist[31:0];
      4'd9:    return m_ist[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_oeb = VALID; m_ien = '0; m_ist = '0; m_irq = 1'b0;
    exp_ack = 1'b0; acc_pend = 1'b0; exp_rd = '0;
    hist.delete();
  endtask

  // Advances the model across one rising edge. The IN value the design sees at an edge is the
  // pad value from SYNC_STAGES edges earlier; a rise is that value against the one before it.
  task automatic model_edge();
    logic [63:0] in_seen, rise, w1c, mask, wdat;
    logic        irq_next;
    in_seen  = hget(SYNC_STAGES - 1);
    rise     = in_seen & ~hget(SYNC_STAGES);
    irq_next = (m_ist & m_ien) != 64'h0;
    w1c      = '0;
    exp_ack  = 1'b0;
    if (acc_pend) begin
      acc_pend = 1'b0;
      exp_ack  = 1'b1;
      exp_rd   = model_read(acc_word, in_seen);
      if (acc_we) begin
        mask = '0;
        for (int b = 0; b < 4; b++) if (acc_sel[b]) mask |= 64'hFF << (8 * b);
        if (acc_word[0]) mask = mask << 32;
        mask &= VALID;
        wdat = {acc_dat, acc_dat};
        case (acc_word)
          4'd0, 4'd1: m_out = (m_out & ~mask) | (wdat & mask);
          4'd2, 4'd3: m_oeb = (m_oeb & ~mask) | (wdat & mask);
          4'd6, 4'd7: m_ien = (m_ien & ~mask) | (wdat & mask);
          4'd8, 4'd9: w1c   = wdat & mask;
          default: ;
        endcase
      end
    end
    m_ist = (m_ist & ~w1c) | rise;
    m_irq = irq_next;
    hist.push_front(64'(io_in));
    if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_back());
  endtask

  task automatic cycle();
    @(posedge core_clk);
    model_edge();
    @(negedge core_clk);
    if (wb_if.wb_ack_o) ack_seen++;
    check("ack", 64'(wb_if.wb_ack_o), 64'(exp_ack));
    if (exp_ack && !acc_we) check("rdata", 64'(wb_if.wb_dat_o), 64'(exp_rd));
    else if (!exp_ack)      check("dat_idle", 64'(wb_if.wb_dat_o), 64'h0);
    check("io_out", 64'(io_out), m_out);
    check("io_oeb", 64'(io_oeb), m_oeb);
    check("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic bus_start(input bit we, input logic [3:0] word, input logic [31:0] dat,
                           input logic [3:0] sel);
    logic [31:0] a;
    a      = adr_noise ? $urandom : 32'h0;
    a[5:2] = word;
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = we;
    wb_if.wb_sel_i = sel;  wb_if.wb_adr_i = a;    wb_if.wb_dat_i = dat;
    acc_pend = 1'b1; acc_we = we; acc_word = word; acc_sel = sel; acc_dat = dat;
  endtask

  task automatic bus_drop();
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
  endtask

  // One transfer; hold keeps the strobe up through the acknowledge cycle as well.
  task automatic bus(input bit we, input logic [3:0] word, input logic [31:0] dat,
                     input logic [3:0] sel, input bit hold, output logic [31:0] rd);
    bus_start(we, word, dat, sel);
    cycle();
    rd = wb_if.wb_dat_o;
    if (hold) cycle();
    bus_drop();
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [63:0] r;
    adr_noise = 1'b0;
    acc_we = 1'b0; acc_word = '0; acc_sel = '0; acc_dat = '0;
    bus_drop();
    wb_if.wb_sel_i = '0; wb_if.wb_adr_i = '0; wb_if.wb_dat_i = '0;
    io_in = '0;
    core_rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge core_clk);
    core_rstn = 1'b1;

    check("rst_oeb", 64'(io_oeb), VALID);
    check("rst_out", 64'(io_out), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_ack", 64'(wb_if.wb_ack_o), 64'h0);
    bus(1'b0, 4'd4, 32'h0, 4'hF, 1'b0, rd);
    check("in_lo_rst", 64'(rd), 64'h0);

    bus(1'b1, 4'd0, 32'hA5A5_A5A5, 4'b0011, 1'b0, rd);
    check("out_lo_sel", 64'(io_out), 64'h0000_A5A5);

    bus(1'b1, 4'd3, 32'hFFFF_FFC0, 4'hF, 1'b0, rd);
    check("oeb_hi_pads", 64'(io_oeb[37:32]), 64'h0);
    bus(1'b0, 4'd3, 32'h0, 4'hF, 1'b0, rd);
    check("oeb_hi_rd", 64'(rd), 64'h0);

    bus(1'b1, 4'd6, 32'h20, 4'hF, 1'b0, rd);
    io_in[5] = 1'b1;
    repeat (2) cycle();
    bus(1'b0, 4'd8, 32'h0, 4'hF, 1'b0, rd);
    check("ist_early", 64'(rd), 64'h0);
    bus(1'b0, 4'd8, 32'h0, 4'hF, 1'b0, rd);
    check("ist_set", 64'(rd), 64'h20);
    check("irq_set", 64'(irq), 64'h1);
    bus(1'b1, 4'd8, 32'h20, 4'hF, 1'b0, rd);
    check("irq_clr", 64'(irq), 64'h0);

    io_in[3] = 1'b1;
    repeat (2) cycle();
    bus(1'b1, 4'd8, 32'h8, 4'hF, 1'b0, rd);
    bus(1'b0, 4'd8, 32'h0, 4'hF, 1'b0, rd);
    check("ist_set_wins", 64'(rd & 32'h8), 64'h8);

    ack_seen = 0;
    bus(1'b1, 4'd1, 32'h15, 4'hF, 1'b1, rd);
    repeat (3) cycle();
    check("held_acks", 64'(ack_seen), 64'h1);
    check("held_out_hi", 64'(io_out[37:32]), 64'h15);

    bus(1'b0, 4'd15, 32'h0, 4'hF, 1'b0, rd);
    check("unmapped_rd", 64'(rd), 64'h0);
    bus(1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);

    bus_start(1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF);
    cycle();
    core_rstn = 1'b0;
    #1;
    check("rst_mid_ack", 64'(wb_if.wb_ack_o), 64'h0);
    check("rst_mid_out", 64'(io_out), 64'h0);
    check("rst_mid_oeb", 64'(io_oeb), VALID);
    model_reset();
    bus_drop();
    @(negedge core_clk);
    core_rstn = 1'b1;
    repeat (2) cycle();

    adr_noise = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = {$urandom, $urandom};
        io_in = r[NUM_IO-1:0];
      end
      repeat ($urandom_range(0, 2)) cycle();
      bus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
